tile_cursor_ctrl: RTL

Parametrised cursor/tile-edit controller for the tile-map game screen. It drives a blinking cursor over a COLS x ROWS tile table through the table's read (`get`) and write (`update`) ports, and preserves the tile underneath. It restores that tile before every move, and lets the player edit the tile's index and attribute fields in place. It sits between the button inputs and the tile-table controller, in the px_clk domain, and succeeds the fixed 40x30 test-code block.

---
 rtl/tile_cursor_ctrl.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/tile_cursor_ctrl.sv
// Blinking cursor over a COLS x ROWS tile table: reads the tile under the cursor,
// blinks it on game ticks, restores it before each move, and edits its fields in place.
module tile_cursor_ctrl #(
  parameter int              COLS        = 40,
  parameter int              ROWS        = 30,
  parameter int              POSW        = 6,
  parameter int              SPRW        = 8,
  parameter int              IDXW        = 5,
  parameter int              TICK_FRAMES = 21,
  parameter int              INIT_X      = 6,
  parameter int              INIT_Y      = 6,
  parameter logic [SPRW-1:0] CURSOR_SPR  = SPRW'(7)
) (
  input  logic            px_clk,
  input  logic            rst,
  input  logic            endframe,
  input  logic            left,
  input  logic            right,
  input  logic            up,
  input  logic            down,
  input  logic            btn1,
  input  logic            btn2,
  input  logic            busy,
  input  logic            rd_valid,
  input  logic [SPRW-1:0] read_sprite,
  output logic            get,
  output logic            update,
  output logic [POSW-1:0] posx,
  output logic [POSW-1:0] posy,
  output logic [SPRW-1:0] sprite,
  output logic            phase
);

  localparam int FCW = (TICK_FRAMES > 1) ? $clog2(TICK_FRAMES) : 1;
  localparam int ATW = SPRW - IDXW;

  typedef enum logic [2:0] {
    S_READ_REQ, S_READ_WAIT, S_IDLE, S_WRITE, S_RESTORE
  } state_t;

  state_t          state_q, state_d;
  logic [FCW-1:0]  frame_q, frame_d;
  logic            pend_q, pend_d;
  logic            phase_q, phase_d;
  logic            get_q, get_d;
  logic            update_q, update_d;
  logic [POSW-1:0] posx_q, posx_d;
  logic [POSW-1:0] posy_q, posy_d;
  logic [POSW-1:0] tgtx_q, tgtx_d;
  logic [POSW-1:0] tgty_q, tgty_d;
  logic [SPRW-1:0] sprite_q, sprite_d;
  logic [SPRW-1:0] saved_q, saved_d;

  logic            tick, consume, do_edit;
  logic [POSW-1:0] x_dec, x_inc, y_dec, y_inc;
  logic [IDXW-1:0] idx_nxt;
  logic [ATW-1:0]  att_nxt;

  assign tick = endframe && (frame_q == FCW'(TICK_FRAMES - 1));

  // Neighbour coordinates with wrap-around at the grid edges.
  assign x_dec = (posx_q == '0) ? POSW'(COLS - 1) : posx_q - POSW'(1);
  assign x_inc = (posx_q == POSW'(COLS - 1)) ? '0 : posx_q + POSW'(1);
  assign y_dec = (posy_q == '0) ? POSW'(ROWS - 1) : posy_q - POSW'(1);
  assign y_inc = (posy_q == POSW'(ROWS - 1)) ? '0 : posy_q + POSW'(1);

  assign idx_nxt = saved_q[IDXW-1:0] + IDXW'(btn1);
  assign att_nxt = saved_q[SPRW-1:IDXW] + ATW'(btn2);

  always_comb begin
    state_d  = state_q;
    frame_d  = frame_q;
    get_d    = get_q;
    update_d = update_q;
    posx_d   = posx_q;
    posy_d   = posy_q;
    tgtx_d   = tgtx_q;
    tgty_d   = tgty_q;
    sprite_d = sprite_q;
    saved_d  = saved_q;
    consume  = 1'b0;
    do_edit  = 1'b0;

    if (endframe) frame_d = tick ? '0 : frame_q + FCW'(1);

    case (state_q)
      S_READ_REQ: begin
        // get is raised here too so the first request after reset appears unprompted
        if (get_q && !busy) begin
          get_d   = 1'b0;
          state_d = S_READ_WAIT;
        end else begin
          get_d = 1'b1;
        end
      end
      S_READ_WAIT: begin
        if (rd_valid) begin
          saved_d = read_sprite;
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        if (pend_q) begin
          consume  = 1'b1;
          update_d = 1'b1;
          if (left || right || up || down) begin
            tgtx_d   = posx_q;
            tgty_d   = posy_q;
            if (left)       tgtx_d = x_dec;
            else if (right) tgtx_d = x_inc;
            else if (up)    tgty_d = y_dec;
            else            tgty_d = y_inc;
            sprite_d = saved_q;
            state_d  = S_RESTORE;
          end else if (btn1 || btn2) begin
            do_edit  = 1'b1;
            saved_d  = {att_nxt, idx_nxt};
            sprite_d = {att_nxt, idx_nxt};
            state_d  = S_WRITE;
          end else begin
            sprite_d = phase_q ? CURSOR_SPR : saved_q;
            state_d  = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        if (update_q && !busy) begin
          update_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      S_RESTORE: begin
        if (update_q && !busy) begin
          update_d = 1'b0;
          posx_d   = tgtx_q;
          posy_d   = tgty_q;
          get_d    = 1'b1;
          state_d  = S_READ_REQ;
        end
      end
      default: begin
        get_d    = 1'b0;
        update_d = 1'b0;
        state_d  = S_READ_REQ;
      end
    endcase

    // A tick landing on the consuming cycle re-arms the flag.
    pend_d  = tick | (pend_q & ~consume);
    phase_d = do_edit ? 1'b0 : (phase_q ^ tick);
  end

  always_ff @(posedge px_clk) begin
    if (rst) begin
      state_q  <= S_READ_REQ;
      frame_q  <= '0;
      pend_q   <= 1'b0;
      phase_q  <= 1'b0;
      get_q    <= 1'b0;
      update_q <= 1'b0;
      posx_q   <= POSW'(INIT_X);
      posy_q   <= POSW'(INIT_Y);
      tgtx_q   <= POSW'(INIT_X);
      tgty_q   <= POSW'(INIT_Y);
      sprite_q <= '0;
      saved_q  <= '0;
    end else begin
      state_q  <= state_d;
      frame_q  <= frame_d;
      pend_q   <= pend_d;
      phase_q  <= phase_d;
      get_q    <= get_d;
      update_q <= update_d;
      posx_q   <= posx_d;
      posy_q   <= posy_d;
      tgtx_q   <= tgtx_d;
      tgty_q   <= tgty_d;
      sprite_q <= sprite_d;
      saved_q  <= saved_d;
    end
  end

  assign get    = get_q;
  assign update = update_q;
  assign posx   = posx_q;
  assign posy   = posy_q;
  assign sprite = sprite_q;
  assign phase  = phase_q;

endmodule
